mem_rf_nr1w: RTL and testbench

- Parametrised successor to the fixed 16x32 one-read/one-write memory primitive in the E_Mem_bot tile.
- Synthesisable register-file memory with N synchronous read ports and one write port.
- Write port has byte-lane enables. Read-during-write mode, optional output register and a hardware clear sequencer are selectable.
- Instantiated as the BEL behind the Mem tile. It also serves as the simulation model used to check mapped $mem_v2 cells.

---
 rtl/mem_rf_pkg.sv | 18 +
 rtl/mem_rf_nr1w_if.sv | 32 +++
 rtl/mem_rf_rdport.sv | 78 +++++++
 rtl/mem_rf_nr1w.sv | 117 +++++++++++
 tb/tb_mem_rf_nr1w.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_rf_pkg.sv
// Shared types and sizing helpers for the N-read / 1-write register-file memory.
package mem_rf_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  // Address width: max(1, clog2(depth)).
  function automatic int unsigned abits(input int unsigned depth);
    return (depth <= 32'd2) ? 32'd1 : 32'($clog2(depth));
  endfunction

  function automatic int unsigned lanes(input int unsigned width, input int unsigned lane_w);
    return width / lane_w;
  endfunction

endpackage

// File: rtl/mem_rf_nr1w_if.sv
// Write port, packed read ports and busy flag of the register-file memory.
interface mem_rf_nr1w_if import mem_rf_pkg::*; #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned LANE_W   = 8
) ();

  localparam int unsigned ABITS = abits(DEPTH);
  localparam int unsigned LANES = lanes(WIDTH, LANE_W);

  logic                      BUSY;
  logic                      WR_EN;
  logic [ABITS-1:0]          WR_ADDR;
  logic [WIDTH-1:0]          WR_DATA;
  logic [LANES-1:0]          WR_BE;
  logic [RD_PORTS-1:0]       RD_EN;
  logic [RD_PORTS*ABITS-1:0] RD_ADDR;
  logic [RD_PORTS*WIDTH-1:0] RD_DATA;
  logic [RD_PORTS-1:0]       RD_VALID;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, WR_BE, RD_EN, RD_ADDR,
    input  BUSY, RD_DATA, RD_VALID
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, WR_BE, RD_EN, RD_ADDR,
    output BUSY, RD_DATA, RD_VALID
  );

endinterface

// File: rtl/mem_rf_rdport.sv
// One synchronous read port: range check, write bypass, optional output stage.
module mem_rf_rdport #(
  parameter int unsigned     WIDTH         = 32,
  parameter int unsigned     DEPTH         = 16,
  parameter int unsigned     ABITS         = 4,
  parameter int unsigned     LANE_W        = 8,
  parameter bit              TRANSPARENT   = 1'b1,
  parameter bit              OUT_REG       = 1'b0,
  parameter logic [WIDTH-1:0] RD_SRST_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    busy,
  input  logic                    rd_en,
  input  logic [ABITS-1:0]        rd_addr,
  input  logic [WIDTH-1:0]        mem_word,
  input  logic                    wr_fire,
  input  logic [ABITS-1:0]        wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [WIDTH/LANE_W-1:0] wr_be,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid
);

  localparam int unsigned LANES = WIDTH / LANE_W;

  logic [WIDTH-1:0] word_c;
  logic             fire_c;
  logic [WIDTH-1:0] s1_data_q;
  logic             s1_valid_q;

  // Out-of-range reads return zero; same-address writes merge per lane when transparent.
  always_comb begin
    word_c = '0;
    if (32'(rd_addr) < DEPTH) begin
      word_c = mem_word;
      if (TRANSPARENT && wr_fire && (wr_addr == rd_addr)) begin
        for (int i = 0; i < LANES; i++) begin
          if (wr_be[i]) word_c[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign fire_c = rd_en && !busy;

  always_ff @(posedge clk) begin
    if (srst) begin
      s1_data_q  <= RD_SRST_VALUE;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= fire_c;
      if (fire_c) s1_data_q <= word_c;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [WIDTH-1:0] s2_data_q;
    logic             s2_valid_q;

    always_ff @(posedge clk) begin
      if (srst) begin
        s2_data_q  <= RD_SRST_VALUE;
        s2_valid_q <= 1'b0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign rd_data  = s2_data_q;
    assign rd_valid = s2_valid_q;
  end else begin : g_no_out_reg
    assign rd_data  = s1_data_q;
    assign rd_valid = s1_valid_q;
  end

endmodule

// File: rtl/mem_rf_nr1w.sv
// N-read / 1-write register-file memory with byte-lane writes and a reset-time clear sweep.
module mem_rf_nr1w import mem_rf_pkg::*; #(
  parameter int unsigned      WIDTH          = 32,
  parameter int unsigned      DEPTH          = 16,
  parameter int unsigned      RD_PORTS       = 2,
  parameter int unsigned      LANE_W         = 8,
  parameter bit               TRANSPARENT    = 1'b1,
  parameter bit               OUT_REG        = 1'b0,
  parameter bit               CLEAR_ON_RESET = 1'b1,
  parameter logic [WIDTH-1:0] RD_SRST_VALUE  = '0
) (
  input  logic          UserCLK,
  input  logic          SRST,
  mem_rf_nr1w_if.slave  bus
);

  localparam int unsigned ABITS = abits(DEPTH);
  localparam int unsigned LANES = lanes(WIDTH, LANE_W);

  if (WIDTH % LANE_W != 0) begin : g_chk_lane
    $error("mem_rf_nr1w: WIDTH must be a multiple of LANE_W");
  end
  if (RD_PORTS < 1 || RD_PORTS > 4) begin : g_chk_ports
    $error("mem_rf_nr1w: RD_PORTS must be in 1..4");
  end
  if (DEPTH < 2) begin : g_chk_depth
    $error("mem_rf_nr1w: DEPTH must be at least 2");
  end

  state_e           state_q, state_d;
  logic [ABITS-1:0] cnt_q, cnt_d;
  logic             busy_q;
  logic             clr_we_c;
  logic             wr_fire_c;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge UserCLK) begin
    if (SRST) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= CLEAR_ON_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ST_CLEAR);
    end
  end

  // Clear sweep: one zero word per cycle, DEPTH cycles in total.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_c = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we_c = 1'b1;
        if (cnt_q == ABITS'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ABITS'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_fire_c = (state_q == ST_IDLE) && bus.WR_EN && (32'(bus.WR_ADDR) < DEPTH);
  assign bus.BUSY  = busy_q;

  always_ff @(posedge UserCLK) begin
    if (!SRST) begin
      if (clr_we_c) begin
        mem[cnt_q] <= '0;
      end else if (wr_fire_c) begin
        for (int i = 0; i < LANES; i++) begin
          if (bus.WR_BE[i]) mem[bus.WR_ADDR][i*LANE_W +: LANE_W] <= bus.WR_DATA[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ABITS-1:0] addr;
    logic [WIDTH-1:0] data;
    logic             valid;

    assign addr = bus.RD_ADDR[p*ABITS +: ABITS];

    mem_rf_rdport #(
      .WIDTH         (WIDTH),
      .DEPTH         (DEPTH),
      .ABITS         (ABITS),
      .LANE_W        (LANE_W),
      .TRANSPARENT   (TRANSPARENT),
      .OUT_REG       (OUT_REG),
      .RD_SRST_VALUE (RD_SRST_VALUE)
    ) u_rdport (
      .clk      (UserCLK),
      .srst     (SRST),
      .busy     (busy_q),
      .rd_en    (bus.RD_EN[p]),
      .rd_addr  (addr),
      .mem_word (mem[addr]),
      .wr_fire  (wr_fire_c),
      .wr_addr  (bus.WR_ADDR),
      .wr_data  (bus.WR_DATA),
      .wr_be    (bus.WR_BE),
      .rd_data  (data),
      .rd_valid (valid)
    );

    assign bus.RD_DATA[p*WIDTH +: WIDTH] = data;
    assign bus.RD_VALID[p]               = valid;
  end

endmodule

// File: tb/tb_mem_rf_nr1w.sv
// Bench for mem_rf_nr1w: default config plus a 12-deep, 3-port, registered, non-transparent config.
module tb_mem_rf_nr1w;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [1:0]  re;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [1:0]  ev;
  } vec_t;

  localparam int NV = 10;
  localparam logic [31:0] SRST1_VAL = 32'hCAFEF00D;

  logic clk = 1'b0;
  logic srst0, srst1;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] mdl0 [16];
  logic [31:0] last0 [2];
  logic [31:0] mdl1 [12];
  logic [31:0] last1 [3];
  vec_t        tbl [NV];

  always #5 clk = ~clk;

  mem_rf_nr1w_if #(.WIDTH(32), .DEPTH(16), .RD_PORTS(2), .LANE_W(8)) b0 ();
  mem_rf_nr1w_if #(.WIDTH(32), .DEPTH(12), .RD_PORTS(3), .LANE_W(8)) b1 ();

  mem_rf_nr1w #(
    .WIDTH(32), .DEPTH(16), .RD_PORTS(2), .LANE_W(8),
    .TRANSPARENT(1'b1), .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1), .RD_SRST_VALUE(32'h0)
  ) dut0 (
    .UserCLK (clk),
    .SRST    (srst0),
    .bus     (b0.slave)
  );

  mem_rf_nr1w #(
    .WIDTH(32), .DEPTH(12), .RD_PORTS(3), .LANE_W(8),
    .TRANSPARENT(1'b0), .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1), .RD_SRST_VALUE(SRST1_VAL)
  ) dut1 (
    .UserCLK (clk),
    .SRST    (srst1),
    .bus     (b1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // One read transaction on dut1 (optionally with a full-word write at the same edge).
  task automatic d1_read(input logic [2:0] re, input int a0, input int a1, input int a2,
                         input logic we, input int wa, input logic [31:0] wd);
    int          a [3];
    logic [95:0] prev;
    a[0] = a0; a[1] = a1; a[2] = a2;
    prev = {last1[2], last1[1], last1[0]};
    b1.RD_EN   = re;
    b1.RD_ADDR = {4'(a2), 4'(a1), 4'(a0)};
    b1.WR_EN   = we;
    b1.WR_ADDR = 4'(wa);
    b1.WR_DATA = wd;
    b1.WR_BE   = 4'hF;
    for (int p = 0; p < 3; p++) if (re[p]) last1[p] = (a[p] < 12) ? mdl1[a[p]] : 32'h0;
    if (we && wa < 12) mdl1[wa] = wd;
    tick();
    b1.RD_EN = '0;
    b1.WR_EN = 1'b0;
    chk("d1_lat_valid", 128'(b1.RD_VALID), 128'(3'b000));
    chk("d1_lat_hold", 128'(b1.RD_DATA), 128'(prev));
    tick();
    chk("d1_rd_data", 128'(b1.RD_DATA), 128'({last1[2], last1[1], last1[0]}));
    chk("d1_rd_valid", 128'(b1.RD_VALID), 128'(re));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [1:0]  ev;
    logic [3:0]  ra [2];
    logic        we;
    logic [3:0]  wa, be;
    logic [31:0] wd;
    logic [1:0]  re;

    tbl[0] = '{1'b1, 4'd3, 32'hAABBCCDD, 4'hF, 2'b00, 4'd0, 4'd0, 32'h00000000, 32'h00000000, 2'b00};
    tbl[1] = '{1'b1, 4'd3, 32'h11223344, 4'h5, 2'b00, 4'd0, 4'd0, 32'h00000000, 32'h00000000, 2'b00};
    tbl[2] = '{1'b0, 4'd0, 32'h00000000, 4'h0, 2'b11, 4'd3, 4'd3, 32'hAA22CC44, 32'hAA22CC44, 2'b11};
    tbl[3] = '{1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 2'b11, 4'd5, 4'd3, 32'hDEADBEEF, 32'hAA22CC44, 2'b11};
    tbl[4] = '{1'b1, 4'd5, 32'h00000000, 4'h0, 2'b11, 4'd5, 4'd4, 32'hDEADBEEF, 32'h00000000, 2'b11};
    tbl[5] = '{1'b1, 4'd5, 32'h12345678, 4'h8, 2'b01, 4'd5, 4'd0, 32'h12ADBEEF, 32'h00000000, 2'b01};
    tbl[6] = '{1'b0, 4'd0, 32'h00000000, 4'h0, 2'b10, 4'd0, 4'd5, 32'h12ADBEEF, 32'h12ADBEEF, 2'b10};
    tbl[7] = '{1'b0, 4'd3, 32'hFFFFFFFF, 4'hF, 2'b01, 4'd3, 4'd0, 32'hAA22CC44, 32'h12ADBEEF, 2'b01};
    tbl[8] = '{1'b1, 4'd3, 32'hFFFFFFFF, 4'h0, 2'b11, 4'd3, 4'd3, 32'hAA22CC44, 32'hAA22CC44, 2'b11};
    tbl[9] = '{1'b0, 4'd0, 32'h00000000, 4'h0, 2'b00, 4'd0, 4'd0, 32'hAA22CC44, 32'hAA22CC44, 2'b00};

    srst0 = 1'b1; srst1 = 1'b1;
    b0.WR_EN = 1'b0; b0.WR_ADDR = '0; b0.WR_DATA = '0; b0.WR_BE = '0; b0.RD_EN = '0; b0.RD_ADDR = '0;
    b1.WR_EN = 1'b0; b1.WR_ADDR = '0; b1.WR_DATA = '0; b1.WR_BE = '0; b1.RD_EN = '0; b1.RD_ADDR = '0;
    tick();

    chk("d0_rst_busy", 128'(b0.BUSY), 128'(1'b1));
    chk("d0_rst_valid", 128'(b0.RD_VALID), 128'(2'b00));
    chk("d0_rst_data", 128'(b0.RD_DATA), 128'(64'h0));
    chk("d1_rst_busy", 128'(b1.BUSY), 128'(1'b1));
    chk("d1_rst_valid", 128'(b1.RD_VALID), 128'(3'b000));
    chk("d1_rst_data", 128'(b1.RD_DATA), 128'({3{SRST1_VAL}}));

    // dut0: full clear sweep, BUSY counted from the first post-reset sample
    srst0 = 1'b0;
    n = 0;
    while (b0.BUSY === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("d0_clear_len", 128'(n), 128'(16));
    chk("d0_busy_low", 128'(b0.BUSY), 128'(1'b0));

    for (int i = 0; i < 16; i++) mdl0[i] = 32'h0;
    for (int i = 0; i < 16; i++) begin
      b0.RD_EN   = 2'b11;
      b0.RD_ADDR = {4'(15 - i), 4'(i)};
      tick();
      chk($sformatf("d0_clear_rd%0d", i), 128'(b0.RD_DATA), 128'(64'h0));
      chk($sformatf("d0_clear_v%0d", i), 128'(b0.RD_VALID), 128'(2'b11));
    end

    // dut0: directed vector table
    for (int i = 0; i < NV; i++) begin
      b0.WR_EN   = tbl[i].we;
      b0.WR_ADDR = tbl[i].wa;
      b0.WR_DATA = tbl[i].wd;
      b0.WR_BE   = tbl[i].be;
      b0.RD_EN   = tbl[i].re;
      b0.RD_ADDR = {tbl[i].ra1, tbl[i].ra0};
      tick();
      chk($sformatf("vec%0d_data", i), 128'(b0.RD_DATA), 128'({tbl[i].ed1, tbl[i].ed0}));
      chk($sformatf("vec%0d_valid", i), 128'(b0.RD_VALID), 128'(tbl[i].ev));
      if (tbl[i].we) mdl0[tbl[i].wa] = merge(mdl0[tbl[i].wa], tbl[i].wd, tbl[i].be);
      last0[0] = tbl[i].ed0;
      last0[1] = tbl[i].ed1;
    end

    // dut0: random traffic against the array model
    for (int c = 0; c < 300; c++) begin
      we = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      re = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) ra[p] = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      ev = '0;
      for (int p = 0; p < 2; p++) begin
        if (re[p]) begin
          last0[p] = (we && wa == ra[p]) ? merge(mdl0[ra[p]], wd, be) : mdl0[ra[p]];
          ev[p] = 1'b1;
        end
      end
      if (we) mdl0[wa] = merge(mdl0[wa], wd, be);
      b0.WR_EN = we; b0.WR_ADDR = wa; b0.WR_DATA = wd; b0.WR_BE = be;
      b0.RD_EN = re; b0.RD_ADDR = {ra[1], ra[0]};
      tick();
      chk($sformatf("rnd%0d_data", c), 128'(b0.RD_DATA), 128'({last0[1], last0[0]}));
      chk($sformatf("rnd%0d_valid", c), 128'(b0.RD_VALID), 128'(ev));
    end
    b0.WR_EN = 1'b0; b0.RD_EN = '0;

    // dut1: reset in the middle of the sweep restarts it
    srst1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("d1_busy_pre%0d", i), 128'(b1.BUSY), 128'(1'b1));
    end
    srst1 = 1'b1;
    tick();
    srst1 = 1'b0;
    n = 0;
    while (b1.BUSY === 1'b1 && n < 100) begin
      chk($sformatf("d1_busy_valid%0d", n), 128'(b1.RD_VALID), 128'(3'b000));
      b1.RD_EN   = (n == 0) ? 3'b111 : 3'b000;
      b1.RD_ADDR = '0;
      n++;
      tick();
    end
    b1.RD_EN = '0;
    chk("d1_clear_len", 128'(n), 128'(12));
    chk("d1_busy_hold_data", 128'(b1.RD_DATA), 128'({3{SRST1_VAL}}));
    chk("d1_busy_hold_valid", 128'(b1.RD_VALID), 128'(3'b000));
    for (int i = 0; i < 12; i++) mdl1[i] = 32'h0;
    for (int p = 0; p < 3; p++) last1[p] = SRST1_VAL;

    // dut1: in-range and out-of-range writes
    b1.WR_BE = 4'hF;
    b1.WR_EN = 1'b1; b1.WR_ADDR = 4'd1;  b1.WR_DATA = 32'h1;        tick();
    b1.WR_EN = 1'b1; b1.WR_ADDR = 4'd7;  b1.WR_DATA = 32'h7;        tick();
    b1.WR_EN = 1'b1; b1.WR_ADDR = 4'd13; b1.WR_DATA = 32'hFFFFFFFF; tick();
    b1.WR_EN = 1'b1; b1.WR_ADDR = 4'd12; b1.WR_DATA = 32'hEEEEEEEE; tick();
    b1.WR_EN = 1'b0;
    mdl1[1] = 32'h1;
    mdl1[7] = 32'h7;

    d1_read(3'b111, 1, 1, 7, 1'b0, 0, 32'h0);
    d1_read(3'b111, 13, 12, 0, 1'b0, 0, 32'h0);
    for (int g = 0; g < 4; g++) d1_read(3'b111, 3*g, 3*g + 1, 3*g + 2, 1'b0, 0, 32'h0);

    // dut1: non-transparent read of the address being written, then the new value
    d1_read(3'b001, 5, 0, 0, 1'b1, 5, 32'hDEADBEEF);
    d1_read(3'b001, 5, 0, 0, 1'b0, 0, 32'h0);

    // dut1: back-to-back reads through the output stage
    b1.RD_EN = 3'b001; b1.RD_ADDR = {4'd0, 4'd0, 4'd1};
    tick();
    b1.RD_ADDR = {4'd0, 4'd0, 4'd7};
    tick();
    chk("d1_b2b_first", 128'(b1.RD_DATA), 128'({last1[2], last1[1], 32'h1}));
    chk("d1_b2b_first_v", 128'(b1.RD_VALID), 128'(3'b001));
    b1.RD_EN = '0;
    tick();
    chk("d1_b2b_second", 128'(b1.RD_DATA), 128'({last1[2], last1[1], 32'h7}));
    chk("d1_b2b_second_v", 128'(b1.RD_VALID), 128'(3'b001));
    tick();
    chk("d1_b2b_idle_v", 128'(b1.RD_VALID), 128'(3'b000));
    chk("d1_b2b_idle_hold", 128'(b1.RD_DATA), 128'({last1[2], last1[1], 32'h7}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
